if_inst_buf: RTL and testbench
==============================

Name: if_inst_buf

Overview:
- Instruction fetch buffer that sits directly downstream of the instruction fetch unit and upstream of the decode-stage DFF.
- Stores up to DEPTH fetched {pc, instruction} pairs in a small circular FIFO.
- Decouples ROM return timing from decode stalls.
- Discards all buffered entries on a redirect (jump/trap) flush, so stale instructions never reach decode.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).
- XLEN, 32, pc and instruction width; must match `PORT_WORD_WIDTH.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset (`RstEnable = 0).
- flush_i  input  1  redirect from jump/hold control; empties the buffer.
- in_valid_i  input  1  fetch unit presents a valid instruction.
- in_pc_i  input  XLEN  pc of the presented instruction.
- in_inst_i  input  XLEN  presented instruction word.
- in_ready_o  output  1  buffer can accept a push this cycle.
- out_valid_o  output  1  head entry is valid for decode.
- out_pc_o  output  XLEN  pc of the head entry.
- out_inst_o  output  XLEN  instruction of the head entry.
- out_ready_i  input  1  decode accepts the head entry this cycle.
- count_o  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- State: write pointer wr_ptr (AW bits), read pointer rd_ptr (AW bits), occupancy count (AW+1 bits), storage array of DEPTH x {pc, inst}.
- Reset (rst_n low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, therefore out_valid_o = 0, out_pc_o = 0, out_inst_o = 0, count_o = 0, in_ready_o = 1.
  - Storage is not reset.
  - No push or pop occurs while rst_n is low.
- in_ready_o = (count != DEPTH), decoded combinationally from count. There is no pass-through when full.
- out_valid_o = (count != 0).
- out_pc_o and out_inst_o are taken from storage[rd_ptr] when out_valid_o = 1, and forced to `ZeroWord when the buffer is empty.
- push = in_valid_i & in_ready_o & ~flush_i. On a push, storage[wr_ptr] <= {in_pc_i, in_inst_i} and wr_ptr <= wr_ptr + 1.
- pop = out_valid_o & out_ready_i & ~flush_i. On a pop, rd_ptr <= rd_ptr + 1.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged when push and pop occur together.
- Pointers wrap modulo DEPTH by natural AW-bit overflow. Full and empty are distinguished only by count.
- Latency: an entry pushed in cycle N is visible on the outputs with out_valid_o = 1 in cycle N+1. There is no same-cycle bypass, including when the buffer is empty.
- Ordering: strict FIFO. Entries leave in exactly the order they were pushed, including across pointer wrap.
- Flush has priority over everything:
  - In the flush cycle, neither push nor pop takes effect, and any in_valid_i / out_ready_i are ignored.
  - Next edge: wr_ptr = 0, rd_ptr = 0, count = 0.
  - out_valid_o = 0 from the cycle after the flush onward, until a new push.
  - in_ready_o may still read 1 during the flush cycle, but the push is dropped. The upstream unit must re-fetch from the redirected pc.
- Full boundary (count = DEPTH): in_ready_o = 0 and incoming data is held off. A pop in the same cycle does not admit a push. in_ready_o rises in the next cycle.
- Empty boundary (count = 0): out_ready_i has no effect. An underflow is impossible by construction.
- Reset asserted mid-operation: all contents are abandoned immediately, with outputs at their reset values asynchronously. Operation resumes from empty on the first edge after rst_n rises.
- A simultaneous push and pop on a 1-entry buffer is legal: the head advances to the new entry and count stays 1.

Test Plan:
- Reset then idle -> out_valid_o = 0, out_pc_o = 0, out_inst_o = 0, in_ready_o = 1, count_o = 0.
- Push pc=0x0000_0000, inst=0x0000_0013 with out_ready_i = 0 -> next cycle out_valid_o = 1 with those values and count_o = 1. Then set out_ready_i = 1 for one cycle -> out_valid_o = 0 the following cycle.
- Push 5 consecutive entries (pc 0x00..0x10, step 4) with out_ready_i = 0:
  - After 4 pushes, count_o = 4 and in_ready_o = 0.
  - The 5th entry is held off.
  - One pop then pc 0x10 is accepted on the following cycle.
  - Pops return pc 0x04, 0x08, 0x0C, 0x10 in order.
- At count = 2, assert push and pop together for 3 cycles -> count_o stays 2 and the output sequence preserves order.
- At count = 3, assert flush_i together with in_valid_i and out_ready_i -> next cycle count_o = 0 and out_valid_o = 0. No entry is consumed and the pushed entry is not stored.
- Stream 12 entries (pc 0x100 + 4k) with out_ready_i toggling every cycle -> pointers wrap at least twice. All 12 pcs and instructions emerge in order with no loss or duplication. Asserting rst_n low at entry 7 empties the buffer immediately.

Source files
------------

// File: rtl/if_inst_buf.sv
// if_inst_buf: circular {pc, inst} FIFO between fetch and decode.
// A redirect flush empties it so stale instructions never reach decode.
module if_inst_buf #(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  input  logic [XLEN-1:0] in_pc_i,
  input  logic [XLEN-1:0] in_inst_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_inst_o,
  input  logic            out_ready_i,
  output logic [AW:0]     count_o
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic push, pop;
  assign in_ready_o = count != (AW+1)'(DEPTH);
  assign out_valid_o = count != '0;
  assign count_o = count;
  // rst_n gating keeps the unreset storage from being written while in reset
  assign push = in_valid_i & in_ready_o & ~flush_i & rst_n;
  assign pop = out_valid_o & out_ready_i & ~flush_i;
  assign {out_pc_o, out_inst_o} = out_valid_o ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_pc_i, in_inst_i};
endmodule

// File: tb/tb_if_inst_buf.sv
// tb_if_inst_buf: table of hand-computed vectors plus a queue scoreboard
// checking every cycle, then wrapping streams with a mid-stream reset.
module tb_if_inst_buf;
  logic clk = 0, rst_n = 0, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [31:0] in_pc_i = 0, in_inst_i = 0;
  logic in_ready_o, out_valid_o;
  logic [31:0] out_pc_o, out_inst_o;
  logic [2:0] count_o;
  int vectors = 0, miscompares = 0;
  logic [63:0] q[$];

  typedef struct {
    logic v;
    logic [31:0] pc;
    logic rdy, fl;
    logic [2:0] cnt;
    logic ov, ir;
    logic [31:0] opc;
  } vec_t;
  vec_t tbl[19];

  always #5 clk = ~clk;

  if_inst_buf #(.DEPTH(4), .AW(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_ready_i(out_ready_i), .count_o(count_o)
  );

  task automatic cmp(string n, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_model();
    cmp("count", 64'(count_o), 64'(q.size()));
    cmp("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
    cmp("in_ready", 64'(in_ready_o), 64'(q.size() != 4));
    cmp("head", {out_pc_o, out_inst_o}, q.size() != 0 ? q[0] : 64'h0);
  endtask

  task automatic check_empty(string n);
    cmp({n, "_count"}, 64'(count_o), 64'h0);
    cmp({n, "_valid"}, 64'(out_valid_o), 64'h0);
    cmp({n, "_ready"}, 64'(in_ready_o), 64'h1);
    cmp({n, "_head"}, {out_pc_o, out_inst_o}, 64'h0);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic fl, output bit pushed);
    bit pu, po;
    @(negedge clk);
    in_valid_i = v; in_pc_i = pc; in_inst_i = pc + 32'h13;
    out_ready_i = rdy; flush_i = fl;
    pu = v && q.size() != 4 && !fl;
    po = rdy && q.size() != 0 && !fl;
    if (fl) q.delete();
    if (po) void'(q.pop_front());
    if (pu) q.push_back({pc, pc + 32'h13});
    pushed = pu;
    @(posedge clk);
    #1 check_model();
  endtask

  task automatic stream(input int rst_at);
    int k = 0, cyc = 0;
    bit p;
    while (k < 12 && cyc < 200) begin
      if (k == rst_at) begin
        @(negedge clk);
        rst_n = 0; in_valid_i = 0; out_ready_i = 0;
        #1 check_empty("mid_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1; rst_at = -1;
      end
      step(1'b1, 32'h100 + 32'(4 * k), cyc[0], 1'b0, p);
      if (p) k++;
      cyc++;
    end
    if (k < 12) cmp("stream_timeout", 64'(k), 64'd12);
    while (q.size() != 0 && cyc < 300) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, p);
      cyc++;
    end
    cmp("drained", 64'(count_o), 64'h0);
  endtask

  initial begin
    bit p;
    tbl = '{
      '{1, 32'h00, 0, 0, 3'd1, 1, 1, 32'h00},
      '{0, 32'h00, 1, 0, 3'd0, 0, 1, 32'h00},
      '{1, 32'h00, 0, 0, 3'd1, 1, 1, 32'h00},
      '{1, 32'h04, 0, 0, 3'd2, 1, 1, 32'h00},
      '{1, 32'h08, 0, 0, 3'd3, 1, 1, 32'h00},
      '{1, 32'h0C, 0, 0, 3'd4, 1, 0, 32'h00},
      '{1, 32'h10, 0, 0, 3'd4, 1, 0, 32'h00},
      '{1, 32'h10, 1, 0, 3'd3, 1, 1, 32'h04},
      '{1, 32'h10, 0, 0, 3'd4, 1, 0, 32'h04},
      '{0, 32'h00, 1, 0, 3'd3, 1, 1, 32'h08},
      '{0, 32'h00, 1, 0, 3'd2, 1, 1, 32'h0C},
      '{1, 32'h14, 1, 0, 3'd2, 1, 1, 32'h10},
      '{1, 32'h18, 1, 0, 3'd2, 1, 1, 32'h14},
      '{1, 32'h1C, 1, 0, 3'd2, 1, 1, 32'h18},
      '{1, 32'h20, 0, 0, 3'd3, 1, 1, 32'h18},
      '{1, 32'h24, 1, 1, 3'd0, 0, 1, 32'h00},
      '{0, 32'h00, 0, 0, 3'd0, 0, 1, 32'h00},
      '{1, 32'h28, 0, 0, 3'd1, 1, 1, 32'h28},
      '{0, 32'h00, 1, 0, 3'd0, 0, 1, 32'h00}
    };
    repeat (2) @(posedge clk);
    #1 check_empty("reset");
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].fl, p);
      cmp($sformatf("t%0d_count", i), 64'(count_o), 64'(tbl[i].cnt));
      cmp($sformatf("t%0d_valid", i), 64'(out_valid_o), 64'(tbl[i].ov));
      cmp($sformatf("t%0d_ready", i), 64'(in_ready_o), 64'(tbl[i].ir));
      cmp($sformatf("t%0d_pc", i), 64'(out_pc_o), 64'(tbl[i].opc));
      if (tbl[i].ov)
        cmp($sformatf("t%0d_inst", i), 64'(out_inst_o), 64'(tbl[i].opc + 32'h13));
    end
    stream(-1);
    stream(7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
